// File: rtl/pc_alu_stage.sv
// Stage-1 datapath: PC register, ALU operand muxes, ALU, registered result/flag and a return-address stack.
// Optional macro PC_ALU_STAGE_MULT_EN enables ALUOp 8 (unsigned multiply, low WIDTH bits).
module pc_alu_stage #(
  parameter int unsigned    WIDTH     = 16,
  parameter int unsigned    RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic             WEpc,
  input  logic [1:0]       writepc,
  input  logic [1:0]       ALUsrca,
  input  logic [1:0]       ALUsrcb,
  input  logic [3:0]       ALUOp,
  input  logic             push,
  input  logic [WIDTH-1:0] WritePC1,
  input  logic [WIDTH-1:0] ALUsrcA0,
  input  logic [WIDTH-1:0] ALUsrcA2,
  input  logic [WIDTH-1:0] ALUsrcB0,
  output logic [WIDTH-1:0] PCval,
  output logic [WIDTH-1:0] ALUval,
  output logic [WIDTH-1:0] ALUOut,
  output logic             isTrue,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] w_a, w_b, w_alu, w_top;
  logic             w_is_true;
  logic             w_do_push, w_do_pop, w_empty, w_full;
  logic [PTR_W-1:0] w_sp_n, w_waddr;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_we, w_ovf_n, w_unf_n;

  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_sp;
  logic [CNT_W-1:0] r_cnt;

  // Operand muxes and ALU
  always_comb begin
    w_a = ALUOut;
    case (ALUsrca)
      2'd0:    w_a = ALUsrcA0;
      2'd1:    w_a = PCval;
      2'd2:    w_a = ALUsrcA2;
      default: w_a = ALUOut;
    endcase
    w_b = ALUOut;
    case (ALUsrcb)
      2'd0:    w_b = ALUsrcB0;
      2'd1:    w_b = WIDTH'(1);
      2'd2:    w_b = WIDTH'(2);
      default: w_b = ALUOut;
    endcase
    w_alu = '0;
    case (ALUOp)
      4'd0: w_alu = w_a + w_b;
      4'd1: w_alu = w_a - w_b;
      4'd2: w_alu = w_a & w_b;
      4'd3: w_alu = w_a | w_b;
      4'd4: w_alu = w_a ^ w_b;
      4'd5: w_alu = WIDTH'($signed(w_a) < $signed(w_b));
      4'd6: w_alu = WIDTH'(w_a < w_b);
      4'd7: w_alu = w_a << w_b[3:0];
`ifdef PC_ALU_STAGE_MULT_EN
      4'd8: w_alu = w_a * w_b;
`else
      4'd8: w_alu = '0;
`endif
      default: w_alu = '0;
    endcase
    w_is_true = (ALUOp == 4'd5 || ALUOp == 4'd6) ? w_alu[0] : (w_alu == '0);
  end

  assign ALUval = w_alu;
  assign w_top  = r_ras[r_sp];

  // RAS next-state: circular buffer with r_sp pointing at the top entry
  always_comb begin
    w_do_push = en & push;
    w_do_pop  = en & WEpc & (writepc == 2'd2);
    w_empty   = (r_cnt == '0);
    w_full    = (r_cnt == CNT_W'(RAS_DEPTH));
    w_sp_n    = r_sp;
    w_cnt_n   = r_cnt;
    w_we      = 1'b0;
    w_waddr   = r_sp;
    w_ovf_n   = ras_ovf;
    w_unf_n   = ras_unf;
    if (w_do_push && w_do_pop && !w_empty) begin
      w_we = 1'b1;
    end else if (w_do_push) begin
      // Empty push+pop degenerates to an underflowing pop followed by a push
      if (w_do_pop) w_unf_n = 1'b1;
      w_we    = 1'b1;
      w_sp_n  = r_sp + PTR_W'(1);
      w_waddr = w_sp_n;
      if (w_full) w_ovf_n = 1'b1;
      else        w_cnt_n = r_cnt + CNT_W'(1);
    end else if (w_do_pop) begin
      if (w_empty) begin
        w_unf_n = 1'b1;
      end else begin
        w_sp_n  = r_sp - PTR_W'(1);
        w_cnt_n = r_cnt - CNT_W'(1);
      end
    end
  end

  // Architectural state
  always_ff @(posedge CLK) begin
    if (reset) begin
      PCval   <= RESET_PC;
      ALUOut  <= '0;
      isTrue  <= 1'b0;
      r_sp    <= '0;
      r_cnt   <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else if (en) begin
      ALUOut  <= w_alu;
      isTrue  <= w_is_true;
      r_sp    <= w_sp_n;
      r_cnt   <= w_cnt_n;
      ras_ovf <= w_ovf_n;
      ras_unf <= w_unf_n;
      if (WEpc) begin
        case (writepc)
          2'd0:    PCval <= w_alu;
          2'd1:    PCval <= WritePC1;
          2'd2:    PCval <= w_empty ? RESET_PC : w_top;
          default: PCval <= PCval;
        endcase
      end
    end
  end

  // Stack storage needs no reset; r_cnt gates validity
  always_ff @(posedge CLK) begin
    if (!reset && w_we) r_ras[w_waddr] <= w_alu;
  end

endmodule

// File: tb/tb_pc_alu_stage.sv
// Self-checking bench for pc_alu_stage: directed vector table, RAS sequences, random run vs model.
module tb_pc_alu_stage;

  localparam int unsigned W = 16;

  logic          CLK = 1'b0;
  logic          reset, en, WEpc, push;
  logic [1:0]    writepc, ALUsrca, ALUsrcb;
  logic [3:0]    ALUOp;
  logic [W-1:0]  WritePC1, ALUsrcA0, ALUsrcA2, ALUsrcB0;
  logic [W-1:0]  PCval, ALUval, ALUOut;
  logic          isTrue, ras_ovf, ras_unf;

  int checks = 0;
  int errors = 0;

  pc_alu_stage #(.WIDTH(W), .RAS_DEPTH(4), .RESET_PC('0)) dut (
    .CLK(CLK), .reset(reset), .en(en), .WEpc(WEpc), .writepc(writepc),
    .ALUsrca(ALUsrca), .ALUsrcb(ALUsrcb), .ALUOp(ALUOp), .push(push),
    .WritePC1(WritePC1), .ALUsrcA0(ALUsrcA0), .ALUsrcA2(ALUsrcA2), .ALUsrcB0(ALUsrcB0),
    .PCval(PCval), .ALUval(ALUval), .ALUOut(ALUOut), .isTrue(isTrue),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 CLK = ~CLK;

`ifdef PC_ALU_STAGE_MULT_EN
  localparam logic [W-1:0] MUL_3_5 = 16'd15;
  localparam logic         MUL_T   = 1'b0;
`else
  localparam logic [W-1:0] MUL_3_5 = 16'd0;
  localparam logic         MUL_T   = 1'b1;
`endif

  typedef struct {
    logic en, wepc;
    logic [1:0] wp, sa, sb;
    logic [3:0] op;
    logic push;
    logic [W-1:0] wpc1, a0, a2, b0;
    logic [W-1:0] e_pc, e_out;
    logic e_true;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic e, input logic we, input logic [1:0] wp, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [3:0] op, input logic [W-1:0] wpc1,
                     input logic [W-1:0] a0, input logic [W-1:0] a2, input logic [W-1:0] b0,
                     input logic [W-1:0] epc, input logic [W-1:0] eout, input logic et);
    vec_t v;
    v.en = e; v.wepc = we; v.wp = wp; v.sa = sa; v.sb = sb; v.op = op; v.push = 1'b0;
    v.wpc1 = wpc1; v.a0 = a0; v.a2 = a2; v.b0 = b0; v.e_pc = epc; v.e_out = eout; v.e_true = et;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; en = 1'b1; WEpc = 1'b0; push = 1'b0; writepc = 2'd3;
    ALUsrca = 2'd0; ALUsrcb = 2'd0; ALUOp = 4'd0;
    WritePC1 = '0; ALUsrcA0 = '0; ALUsrcA2 = '0; ALUsrcB0 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Reference model state
  logic [W-1:0] m_pc, m_out;
  logic         m_true, m_ovf, m_unf;
  logic [W-1:0] m_ras[$];

  function automatic int to_signed(input logic [W-1:0] v);
    return (int'(v) >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint r;
    case (op)
      4'd0: r = (ua + ub) % 65536;
      4'd1: r = (ua - ub + 65536) % 65536;
      4'd2: r = longint'(a & b);
      4'd3: r = longint'(a | b);
      4'd4: r = longint'(a ^ b);
      4'd5: r = (to_signed(a) < to_signed(b)) ? 1 : 0;
      4'd6: r = (ua < ub) ? 1 : 0;
      4'd7: r = (ua * (64'sd1 <<< (ub % 16))) % 65536;
`ifdef PC_ALU_STAGE_MULT_EN
      4'd8: r = (ua * ub) % 65536;
`endif
      default: r = 0;
    endcase
    return W'(r);
  endfunction

  function automatic logic [W-1:0] ref_operand_a();
    case (ALUsrca)
      2'd0: return ALUsrcA0;
      2'd1: return m_pc;
      2'd2: return ALUsrcA2;
      default: return m_out;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_operand_b();
    case (ALUsrcb)
      2'd0: return ALUsrcB0;
      2'd1: return 16'd1;
      2'd2: return 16'd2;
      default: return m_out;
    endcase
  endfunction

  task automatic model_edge(input logic [W-1:0] alu);
    logic pop;
    pop = WEpc && writepc == 2'd2;
    if (reset) begin
      m_pc = '0; m_out = '0; m_true = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
    end else if (en) begin
      m_true = (ALUOp == 4'd5 || ALUOp == 4'd6) ? alu[0] : (alu == '0);
      m_out  = alu;
      if (WEpc && writepc == 2'd0) m_pc = alu;
      if (WEpc && writepc == 2'd1) m_pc = WritePC1;
      if (pop) begin
        if (m_ras.size() == 0) begin
          m_pc = '0;
          m_unf = 1'b1;
        end else begin
          m_pc = m_ras[$];
          if (push) m_ras[m_ras.size()-1] = alu;
          else void'(m_ras.pop_back());
        end
      end else if (push) begin
        m_ras.push_back(alu);
        if (m_ras.size() > 4) begin
          m_ras.delete(0);
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset_pc", PCval, 16'h0);
    chk("reset_out", ALUOut, 16'h0);
    chk("reset_true", W'(isTrue), 16'h0);
    chk("reset_ovf", W'(ras_ovf), 16'h0);
    chk("reset_unf", W'(ras_unf), 16'h0);

    // Directed ALU/PC vector table
    add(1'b1,1'b1,2'd0,2'd0,2'd0,4'd0, 16'h0,16'h0,16'h0,16'h0,       16'h0000,16'h0000,1'b1);
    add(1'b1,1'b1,2'd0,2'd1,2'd1,4'd0, 16'h0,16'h0,16'h0,16'h0,       16'h0001,16'h0001,1'b0);
    add(1'b1,1'b1,2'd0,2'd1,2'd2,4'd0, 16'h0,16'h0,16'h0,16'h0,       16'h0003,16'h0003,1'b0);
    add(1'b1,1'b1,2'd0,2'd1,2'd2,4'd0, 16'h0,16'h0,16'h0,16'h0,       16'h0005,16'h0005,1'b0);
    add(1'b1,1'b1,2'd0,2'd1,2'd2,4'd1, 16'h0,16'h0,16'h0,16'h0,       16'h0003,16'h0003,1'b0);
    add(1'b1,1'b1,2'd1,2'd0,2'd0,4'd0, 16'h40,16'h5,16'h0,16'h0,      16'h0040,16'h0005,1'b0);
    add(1'b0,1'b1,2'd1,2'd0,2'd0,4'd0, 16'h0,16'h0,16'h0,16'h0,       16'h0040,16'h0005,1'b0);
    add(1'b1,1'b0,2'd0,2'd0,2'd0,4'd1, 16'h0,16'h7,16'h0,16'h7,       16'h0040,16'h0000,1'b1);
    add(1'b1,1'b0,2'd0,2'd0,2'd0,4'd5, 16'h0,16'hFFFF,16'h0,16'h1,    16'h0040,16'h0001,1'b1);
    add(1'b1,1'b0,2'd0,2'd0,2'd0,4'd6, 16'h0,16'hFFFF,16'h0,16'h1,    16'h0040,16'h0000,1'b0);
    add(1'b1,1'b0,2'd0,2'd0,2'd0,4'd7, 16'h0,16'h3,16'h0,16'h24,      16'h0040,16'h0030,1'b0);
    add(1'b1,1'b0,2'd0,2'd0,2'd0,4'd4, 16'h0,16'h00FF,16'h0,16'h0F0F, 16'h0040,16'h0FF0,1'b0);
    add(1'b1,1'b0,2'd0,2'd0,2'd0,4'd2, 16'h0,16'h00FF,16'h0,16'h0F0F, 16'h0040,16'h000F,1'b0);
    add(1'b1,1'b0,2'd0,2'd0,2'd0,4'd3, 16'h0,16'h00FF,16'h0,16'h0F0F, 16'h0040,16'h0FFF,1'b0);
    add(1'b1,1'b0,2'd0,2'd3,2'd1,4'd0, 16'h0,16'h0,16'h0,16'h0,       16'h0040,16'h1000,1'b0);
    add(1'b1,1'b0,2'd0,2'd2,2'd0,4'd0, 16'h0,16'h0,16'h0100,16'h0023, 16'h0040,16'h0123,1'b0);
    add(1'b1,1'b0,2'd0,2'd0,2'd0,4'd15,16'h0,16'h3,16'h0,16'h5,       16'h0040,16'h0000,1'b1);
    add(1'b1,1'b1,2'd0,2'd1,2'd0,4'd0, 16'h0,16'h0,16'h0,16'h0010,    16'h0050,16'h0050,1'b0);
    add(1'b1,1'b0,2'd0,2'd0,2'd0,4'd8, 16'h0,16'h3,16'h0,16'h5,       16'h0050,MUL_3_5,MUL_T);
    add(1'b1,1'b0,2'd0,2'd0,2'd0,4'd1, 16'h0,16'h0,16'h0,16'h1,       16'h0050,16'hFFFF,1'b0);
    add(1'b1,1'b0,2'd0,2'd0,2'd2,4'd0, 16'h0,16'hFFFF,16'h0,16'h0,    16'h0050,16'h0001,1'b0);

    foreach (vt[i]) begin
      en = vt[i].en; WEpc = vt[i].wepc; writepc = vt[i].wp; ALUsrca = vt[i].sa;
      ALUsrcb = vt[i].sb; ALUOp = vt[i].op; push = vt[i].push; WritePC1 = vt[i].wpc1;
      ALUsrcA0 = vt[i].a0; ALUsrcA2 = vt[i].a2; ALUsrcB0 = vt[i].b0;
      step();
      chk($sformatf("vec%0d_pc", i), PCval, vt[i].e_pc);
      chk($sformatf("vec%0d_out", i), ALUOut, vt[i].e_out);
      chk($sformatf("vec%0d_true", i), W'(isTrue), W'(vt[i].e_true));
    end

    // Call/return: push PC+2, jump, return
    do_reset();
    WEpc = 1'b1; writepc = 2'd1; WritePC1 = 16'h0010; step();
    chk("call_pc10", PCval, 16'h0010);
    WEpc = 1'b0; ALUsrca = 2'd1; ALUsrcb = 2'd2; ALUOp = 4'd0; push = 1'b1; step();
    chk("call_push_pc", PCval, 16'h0010);
    push = 1'b0; WEpc = 1'b1; writepc = 2'd1; WritePC1 = 16'h0080; step();
    chk("call_jump", PCval, 16'h0080);
    writepc = 2'd2; step();
    chk("call_return", PCval, 16'h0012);

    // Overflow then underflow on a 4-deep stack
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      ALUsrca = 2'd0; ALUsrcb = 2'd0; ALUsrcB0 = '0; ALUsrcA0 = W'(i); push = 1'b1; step();
      chk($sformatf("push%0d_ovf", i), W'(ras_ovf), (i == 5) ? 16'h1 : 16'h0);
    end
    push = 1'b0; WEpc = 1'b1; writepc = 2'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("pop%0d_pc", i), PCval, (i < 4) ? W'(5 - i) : 16'h0);
      chk($sformatf("pop%0d_unf", i), W'(ras_unf), (i == 4) ? 16'h1 : 16'h0);
    end
    // Stall holds sticky flags; reset clears them even while stalled
    en = 1'b0; WEpc = 1'b0; step();
    chk("stall_ovf", W'(ras_ovf), 16'h1);
    reset = 1'b1; step(); reset = 1'b0; en = 1'b1;
    chk("rst_mid_ovf", W'(ras_ovf), 16'h0);
    chk("rst_mid_unf", W'(ras_unf), 16'h0);
    chk("rst_mid_pc", PCval, 16'h0);

    // Simultaneous push+pop replaces the top
    idle_inputs();
    ALUsrcA0 = 16'h000A; push = 1'b1; step();
    ALUsrcA0 = 16'h000B; WEpc = 1'b1; writepc = 2'd2; step();
    chk("pp_pc", PCval, 16'h000A);
    chk("pp_unf", W'(ras_unf), 16'h0);
    push = 1'b0; step();
    chk("pp_pop_pc", PCval, 16'h000B);
    step();
    chk("pp_under_pc", PCval, 16'h0);
    chk("pp_under_unf", W'(ras_unf), 16'h1);

    // Randomized run against the reference model
    do_reset();
    model_edge('0);
    reset = 1'b1; model_edge('0); reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] exp_alu;
      reset    = ($urandom_range(0, 99) == 0);
      en       = ($urandom_range(0, 3) != 0);
      WEpc     = $urandom_range(0, 1) == 1;
      writepc  = 2'($urandom_range(0, 3));
      ALUsrca  = 2'($urandom_range(0, 3));
      ALUsrcb  = 2'($urandom_range(0, 3));
      ALUOp    = 4'($urandom_range(0, 15));
      push     = ($urandom_range(0, 2) == 0);
      WritePC1 = 16'($urandom);
      ALUsrcA0 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom);
      ALUsrcA2 = 16'($urandom);
      ALUsrcB0 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom);
      if (push && WEpc && writepc == 2'd2 && m_ras.size() == 0) push = 1'b0;
      #1;
      exp_alu = ref_alu(ALUOp, ref_operand_a(), ref_operand_b());
      chk("rnd_aluval", ALUval, exp_alu);
      model_edge(exp_alu);
      step();
      chk("rnd_pc", PCval, m_pc);
      chk("rnd_out", ALUOut, m_out);
      chk("rnd_true", W'(isTrue), W'(m_true));
      chk("rnd_ovf", W'(ras_ovf), W'(m_ovf));
      chk("rnd_unf", W'(ras_unf), W'(m_unf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
